// File: rtl/gene_segment_reader.sv
// Sweeps the padded gene memory and assembles one overlapping segment per
// processing unit, handing each to the unit array over valid/ready.
module gene_segment_reader #(
  parameter int unsigned ELEMENT_SIZE     = 4,
  parameter int unsigned CODON_MAX_LENGTH = 5,
  parameter int unsigned ELEMENT_COUNT    = 32,
  parameter int unsigned GENE_MEM_DEPTH   = 256,
  localparam int unsigned SEGMENT_SIZE          = ELEMENT_COUNT + (CODON_MAX_LENGTH - 1),
  localparam int unsigned GENE_MEM_DEPTH_PADDED = GENE_MEM_DEPTH + (CODON_MAX_LENGTH - 1),
  localparam int unsigned PROC_UNIT_COUNT       = GENE_MEM_DEPTH / ELEMENT_COUNT,
  localparam int unsigned ADDR_W                = $clog2(GENE_MEM_DEPTH_PADDED),
  localparam int unsigned UNIT_W                = $clog2(PROC_UNIT_COUNT),
  localparam int unsigned SEG_W                 = SEGMENT_SIZE * ELEMENT_SIZE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [ELEMENT_SIZE-1:0] mem_rd_data,
  output logic                    seg_valid,
  input  logic                    seg_ready,
  output logic [UNIT_W-1:0]       seg_unit,
  output logic [SEG_W-1:0]        seg_data
);

  localparam int unsigned IDX_W = $clog2(SEGMENT_SIZE);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, FINISH} state_t;

  state_t            state, state_d;
  logic [UNIT_W-1:0] unit, unit_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [ADDR_W-1:0] addr_d;
  logic              pend_valid;
  logic [IDX_W-1:0]  pend_idx;

  // State plus outputs registered from their next-cycle values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      unit      <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      seg_valid <= 1'b0;
      seg_unit  <= '0;
    end else begin
      state     <= state_d;
      unit      <= unit_d;
      idx       <= idx_d;
      busy      <= (state_d != IDLE);
      done      <= (state_d == FINISH);
      mem_rd_en <= (state_d == FETCH);
      mem_addr  <= addr_d;
      seg_valid <= (state_d == PRESENT);
      seg_unit  <= unit_d;
    end
  end

  always_comb begin
    state_d = state;
    unit_d  = unit;
    idx_d   = idx;
    addr_d  = mem_addr;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          unit_d  = '0;
          idx_d   = '0;
        end
      end
      FETCH: begin
        if (idx == IDX_W'(SEGMENT_SIZE - 1)) state_d = WAIT;
        else                                  idx_d   = idx + 1'b1;
      end
      WAIT:    state_d = PRESENT;
      PRESENT: begin
        if (seg_valid && seg_ready) begin
          if (unit == UNIT_W'(PROC_UNIT_COUNT - 1)) begin
            state_d = FINISH;
          end else begin
            state_d = FETCH;
            unit_d  = unit + 1'b1;
            idx_d   = '0;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == FETCH)
      addr_d = ADDR_W'(unit_d) * ADDR_W'(ELEMENT_COUNT) + ADDR_W'(idx_d);
  end

  // Read data lands one cycle after the read; slot i is written the edge after that
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      seg_data   <= '0;
    end else begin
      pend_valid <= mem_rd_en;
      pend_idx   <= idx;
      for (int s = 0; s < int'(SEGMENT_SIZE); s++) begin
        if (pend_valid && (pend_idx == IDX_W'(s)))
          seg_data[s*ELEMENT_SIZE +: ELEMENT_SIZE] <= mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_gene_segment_reader.sv
// Self-checking bench for gene_segment_reader: RAM model, timeline reference
// model and per-cycle output comparison, with directed corner scenarios.
module tb_gene_segment_reader;

  localparam int unsigned ES     = 4;
  localparam int unsigned SEGN   = 36;
  localparam int unsigned SEG_W  = SEGN * ES;
  localparam int unsigned DEPTHP = 260;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             busy;
  logic             done;
  logic             mem_rd_en;
  logic [8:0]       mem_addr;
  logic [ES-1:0]    mem_rd_data;
  logic             seg_valid;
  logic             seg_ready;
  logic [2:0]       seg_unit;
  logic [SEG_W-1:0] seg_data;

  gene_segment_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .seg_valid   (seg_valid),
    .seg_ready   (seg_ready),
    .seg_unit    (seg_unit),
    .seg_data    (seg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk_i(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
  endtask

  task automatic chk_w(input string name, input logic [SEG_W-1:0] act, input logic [SEG_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
  endtask

  // Synchronous RAM, one-cycle latency; junk on the bus when not reading
  logic [ES-1:0] mem [0:DEPTHP-1];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    else           mem_rd_data <= ES'($urandom);
  end

  function automatic logic [SEG_W-1:0] exp_seg(input int u);
    logic [SEG_W-1:0] r;
    r = '0;
    for (int k = 0; k < int'(SEGN); k++) r[k*ES +: ES] = mem[32*u + k];
    return r;
  endfunction

  // Reference timeline: t counts cycles since a unit's fetch began;
  // t 0..35 read, t 36 gap, t 37 offered until accepted
  bit               m_run, m_fin;
  int               m_unit, m_t;
  logic [SEG_W-1:0] m_last;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_fin  <= 1'b0;
      m_unit <= 0;
      m_t    <= 0;
      m_last <= '0;
    end else begin
      m_fin <= 1'b0;
      if (m_run) begin
        if (m_t == 37) begin
          if (seg_ready) begin
            m_last <= exp_seg(m_unit);
            if (m_unit == 7) begin
              m_run <= 1'b0;
              m_fin <= 1'b1;
            end else begin
              m_unit <= m_unit + 1;
              m_t    <= 0;
            end
          end
        end else begin
          m_t <= m_t + 1;
        end
      end else if (!m_fin && start) begin
        m_run  <= 1'b1;
        m_unit <= 0;
        m_t    <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk_i("busy", int'(busy), int'(m_run || m_fin));
    chk_i("done", int'(done), int'(m_fin));
    chk_i("mem_rd_en", int'(mem_rd_en), int'(m_run && m_t < 36));
    if (m_run && m_t < 36) chk_i("mem_addr", int'(mem_addr), 32*m_unit + m_t);
    chk_i("seg_valid", int'(seg_valid), int'(m_run && m_t == 37));
    if (m_run && m_t == 37) begin
      chk_i("seg_unit", int'(seg_unit), m_unit);
      chk_w("seg_data", seg_data, exp_seg(m_unit));
    end
    if (!m_run && !m_fin) chk_w("idle_seg_data", seg_data, m_last);
  end

  int               hs_total = 0;
  int               rd_total = 0;
  int               max_addr = 0;
  logic [SEG_W-1:0] got [0:7];
  always @(posedge clk) begin
    if (rst_n) begin
      if (seg_valid && seg_ready) begin
        hs_total      <= hs_total + 1;
        got[seg_unit] <= seg_data;
      end
      if (mem_rd_en) begin
        rd_total <= rd_total + 1;
        if (int'(mem_addr) > max_addr) max_addr <= int'(mem_addr);
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk_i({tag, "_busy"}, int'(busy), 0);
    chk_i({tag, "_done"}, int'(done), 0);
    chk_i({tag, "_rd_en"}, int'(mem_rd_en), 0);
    chk_i({tag, "_addr"}, int'(mem_addr), 0);
    chk_i({tag, "_valid"}, int'(seg_valid), 0);
    chk_i({tag, "_unit"}, int'(seg_unit), 0);
    chk_w({tag, "_data"}, seg_data, '0);
  endtask

  task automatic check_overlap();
    for (int u = 0; u < 7; u++)
      for (int k = 0; k < 4; k++)
        chk_i("overlap", int'(got[u][(32+k)*ES +: ES]), int'(got[u+1][k*ES +: ES]));
  endtask

  // mode 0 plain, 1 backpressure on unit 2, 2 spurious inputs, 3 reset in unit 5
  task automatic sweep(input int mode, input bit pins);
    int k, done_k, done_n, hs0, rd0;
    bit seen, bp, sp4, p1, p7, stop;
    logic [SEG_W-1:0] snap;
    hs0 = hs_total; rd0 = rd_total;
    done_k = -1; done_n = 0;
    seen = 0; bp = 0; sp4 = 0; p1 = 0; p7 = 0; stop = 0;
    seg_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    k = 0;
    while (!stop && k < 2000) begin
      start = 1'b0;
      if (mode == 2) seg_ready = 1'($urandom_range(0, 1));
      if (done) begin
        done_n++;
        if (!seen) begin
          seen = 1; done_k = k;
          if (mode == 2) start = 1'b1;
        end
      end else if (seen && !busy) begin
        stop = 1;
      end
      if (pins && seg_valid && seg_unit == 3'd1 && !p1) begin
        p1 = 1;
        chk_i("u1_elem0", int'(seg_data[3:0]), 0);
        chk_i("u1_elem35", int'(seg_data[143:140]), 3);
      end
      if (pins && seg_valid && seg_unit == 3'd7 && !p7) begin
        p7 = 1;
        chk_i("u7_elem4", int'(seg_data[19:16]), 4);
        chk_i("u7_elem35", int'(seg_data[143:140]), 3);
      end
      if (mode == 2 && !sp4 && mem_rd_en && mem_addr == 9'd140) begin
        start = 1'b1; sp4 = 1;
      end
      if (mode == 1 && !bp && seg_valid && seg_unit == 3'd2) begin
        snap = seg_data;
        seg_ready = 1'b0;
        repeat (10) begin
          @(negedge clk); k++;
          chk_w("bp_hold_data", seg_data, snap);
          chk_i("bp_hold_unit", int'(seg_unit), 2);
          chk_i("bp_hold_valid", int'(seg_valid), 1);
          chk_i("bp_no_read", int'(mem_rd_en), 0);
        end
        seg_ready = 1'b1;
        @(negedge clk); k++;
        chk_i("bp_u3_rd_en", int'(mem_rd_en), 1);
        chk_i("bp_u3_addr", int'(mem_addr), 96);
        bp = 1;
      end
      if (mode == 3 && mem_rd_en && mem_addr == 9'd170) begin
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
          @(negedge clk);
          chk_i("post_reset_busy", int'(busy), 0);
          chk_i("post_reset_valid", int'(seg_valid), 0);
        end
        stop = 1;
      end
      if (!stop) begin
        @(negedge clk); k++;
      end
    end
    chk_i("sweep_completed", int'(stop), 1);
    if (mode != 3) begin
      chk_i("done_pulses", done_n, 1);
      chk_i("handshakes", hs_total - hs0, 8);
      chk_i("reads", rd_total - rd0, 288);
    end
    if (pins) begin
      chk_i("done_edge", done_k, 304);
      chk_i("u1_seen", int'(p1), 1);
      chk_i("u7_seen", int'(p7), 1);
    end
    if (mode == 1) chk_i("bp_applied", int'(bp), 1);
    if (mode == 2) chk_i("spurious_start_applied", int'(sp4), 1);
  endtask

  initial begin
    start = 1'b0;
    seg_ready = 1'b0;
    rst_n = 1'b1;
    for (int a = 0; a < int'(DEPTHP); a++) mem[a] = ES'(a % 16);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    sweep(0, 1'b1);
    chk_i("max_addr", max_addr, 259);
    repeat (3) @(negedge clk);

    sweep(1, 1'b0);
    repeat (3) @(negedge clk);

    for (int a = 0; a < int'(DEPTHP); a++) mem[a] = ES'($urandom);
    sweep(2, 1'b0);
    check_overlap();
    seg_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk_i("no_restart_busy", int'(busy), 0);

    for (int a = 0; a < int'(DEPTHP); a++) mem[a] = ES'($urandom);
    sweep(3, 1'b0);

    for (int a = 0; a < int'(DEPTHP); a++) mem[a] = ES'($urandom);
    sweep(0, 1'b0);
    chk_w("after_reset_unit0", got[0], exp_seg(0));
    check_overlap();
    chk_i("max_addr_final", max_addr, 259);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
